// File: rtl/pool1_layer.sv
// 2x2 stride-2 signed max-pooling over a raster-ordered multi-channel pixel stream.
// Emits one pooled vector per window, with an optional clamp of negative results to zero.
module pool1_layer #(
    parameter int IN_W      = 26,
    parameter int IN_H      = 34,
    parameter int CH        = 32,
    parameter int DATA_BITS = 32,
    parameter int RELU      = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] data_in  [0:CH-1],
    input  logic                 valid_in,
    output logic [DATA_BITS-1:0] pool_out [0:CH-1],
    output logic                 valid_out,
    output logic                 frame_done
);

    localparam int HALF_W = IN_W / 2;
    localparam int CW     = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int RW     = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam int BW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    localparam logic [CW-1:0] LAST_COL     = CW'(IN_W - 1);
    localparam logic [RW-1:0] LAST_ROW     = RW'(IN_H - 1);
    localparam logic [CW-1:0] LAST_OUT_COL = CW'(2 * HALF_W - 1);
    localparam logic [RW-1:0] LAST_OUT_ROW = RW'(2 * (IN_H / 2) - 1);

    logic [CW-1:0]        r_col;
    logic [RW-1:0]        r_row;
    logic [DATA_BITS-1:0] r_hold     [0:CH-1];
    logic [DATA_BITS-1:0] r_rowbuf   [0:HALF_W-1][0:CH-1];
    logic [DATA_BITS-1:0] r_pool_out [0:CH-1];
    logic                 r_valid_out;
    logic                 r_frame_done;

    logic [BW-1:0]        w_idx;
    logic                 w_col_odd;
    logic                 w_row_odd;
    logic [DATA_BITS-1:0] w_m   [0:CH-1];
    logic [DATA_BITS-1:0] w_p   [0:CH-1];
    logic [DATA_BITS-1:0] w_res [0:CH-1];

    assign w_idx     = BW'(r_col >> 1);
    assign w_col_odd = r_col[0];
    assign w_row_odd = r_row[0];

    // Horizontal pair max, vertical max against the buffered row, then optional clamp.
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            w_m[c]   = ($signed(r_hold[c]) > $signed(data_in[c])) ? r_hold[c] : data_in[c];
            w_p[c]   = ($signed(r_rowbuf[w_idx][c]) > $signed(w_m[c])) ? r_rowbuf[w_idx][c] : w_m[c];
            w_res[c] = ((RELU != 0) && w_p[c][DATA_BITS-1]) ? {DATA_BITS{1'b0}} : w_p[c];
        end
    end

    // Raster position counters, advancing only on accepted beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= {CW{1'b0}};
            r_row <= {RW{1'b0}};
        end else if (valid_in) begin
            if (r_col == LAST_COL) begin
                r_col <= {CW{1'b0}};
                r_row <= (r_row == LAST_ROW) ? {RW{1'b0}} : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end else begin
            r_col <= r_col;
            r_row <= r_row;
        end
    end

    // Left-column hold register of each horizontal pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) r_hold[c] <= {DATA_BITS{1'b0}};
        end else if (valid_in && !w_col_odd) begin
            for (int c = 0; c < CH; c++) r_hold[c] <= data_in[c];
        end else begin
            for (int c = 0; c < CH; c++) r_hold[c] <= r_hold[c];
        end
    end

    // Row buffer is always written in an even row before the odd row reads it, so no reset.
    always_ff @(posedge clk) begin
        if (valid_in && w_col_odd && !w_row_odd) begin
            for (int c = 0; c < CH; c++) r_rowbuf[w_idx][c] <= w_m[c];
        end
    end

    // Registered pooled result, valid pulse and end-of-frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) r_pool_out[c] <= {DATA_BITS{1'b0}};
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
        end else if (valid_in && w_col_odd && w_row_odd) begin
            for (int c = 0; c < CH; c++) r_pool_out[c] <= w_res[c];
            r_valid_out  <= 1'b1;
            r_frame_done <= (r_col == LAST_OUT_COL) && (r_row == LAST_OUT_ROW);
        end else begin
            for (int c = 0; c < CH; c++) r_pool_out[c] <= r_pool_out[c];
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
        end
    end

    assign pool_out   = r_pool_out;
    assign valid_out  = r_valid_out;
    assign frame_done = r_frame_done;

endmodule
